// File: rtl/reg_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one write port.
// Register 0 is hardwired to zero; an optional bypass forwards a same-cycle write to the readers.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_active_c;

  // A write only counts outside reset and never targets r0.
  assign wr_active_c = reset_n && regWrite && (writeReg != '0);

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active_c) begin
      regs[writeReg] <= writeData;
    end
  end

  // Read port 1: r0 and reset force zero; bypass gives write-before-read.
  always_comb begin
    readData1 = '0;
    if (reset_n && (readReg1 != '0)) begin
      readData1 = regs[readReg1];
      if (BYPASS && wr_active_c && (writeReg == readReg1)) begin
        readData1 = writeData;
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    readData2 = '0;
    if (reset_n && (readReg2 != '0)) begin
      readData2 = regs[readReg2];
      if (BYPASS && wr_active_c && (writeReg == readReg2)) begin
        readData2 = writeData;
      end
    end
  end

endmodule
